// File: rtl/inert_fusion_intg.sv
// -----------------------------------------------------------------------------
// inert_fusion_intg
//   Pitch estimator. It integrates an offset-corrected pitch rate and pulls the
//   integrator towards an accelerometer-derived pitch by a fixed step on every
//   sample. An optional calibration phase averages 2^CAL_LOG2 samples and uses
//   the result as the rate and accel offsets.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   vld        in   one-cycle strobe, new ptch_rt/AZ sample
//   ptch_rt    in   raw pitch rate (signed, RATE_W)
//   AZ         in   raw Z acceleration (signed, RATE_W)
//   cal_start  in   one-cycle request to (re)calibrate offsets
//   ptch       out  fused pitch (signed, RATE_W)
//   ptch_vld   out  one-cycle strobe, ptch updated from a new sample
//   cal_done   out  high while offsets are valid (RUN state)
//   sat        out  sticky flag, integrator clipped since last calibration/reset
//
// Pipeline: vld sampled -> stage 1 (offset removal, accel scaling)
//           -> stage 2 (integrate + fuse + saturate) -> ptch register.
// -----------------------------------------------------------------------------
module inert_fusion_intg #(
  parameter int              RATE_W     = 16,
  parameter int              INT_W      = 27,
  parameter int              SHIFT      = 11,
  parameter int              FUDGE      = 327,
  parameter int              FUS_STEP   = 1024,
  parameter int              CAL_LOG2   = 4,
  parameter int              CAL_EN     = 1,
  parameter logic [RATE_W-1:0] RT_OFF_DEF = 16'h0050,
  parameter logic [RATE_W-1:0] AZ_OFF_DEF = 16'h00A0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [RATE_W-1:0] ptch_rt,
  input  logic [RATE_W-1:0] AZ,
  input  logic              cal_start,
  output logic [RATE_W-1:0] ptch,
  output logic              ptch_vld,
  output logic              cal_done,
  output logic              sat
);

  localparam int ACC_W = RATE_W + CAL_LOG2;
  localparam int SUM_W = INT_W + 2;
  localparam int PRD_W = RATE_W + 33;

  localparam logic [CAL_LOG2-1:0] CNT_ONE  = 1;
  localparam logic [CAL_LOG2-1:0] CNT_LAST = '1;

  localparam logic signed [SUM_W-1:0] INT_MAX = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] INT_MIN = {3'b111, {(INT_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] FUS_P   = SUM_W'(FUS_STEP);
  localparam logic signed [SUM_W-1:0] FUS_N   = -FUS_P;
  localparam logic signed [32:0]      FUDGE_S = {1'b0, 32'(FUDGE)};

  typedef enum logic {ST_CAL = 1'b0, ST_RUN = 1'b1} state_t;

  localparam state_t ST_RST = (CAL_EN != 0) ? ST_CAL : ST_RUN;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [CAL_LOG2-1:0]       cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   rt_sum_q, rt_sum_d;
  logic signed [ACC_W-1:0]   az_sum_q, az_sum_d;
  logic signed [RATE_W-1:0]  rt_off_q, rt_off_d;
  logic signed [RATE_W-1:0]  az_off_q, az_off_d;
  logic                      s1_vld_q, s1_vld_d;
  logic signed [INT_W-1:0]   comp_q, comp_d;
  logic signed [RATE_W-1:0]  ptch_acc_q, ptch_acc_d;
  logic signed [INT_W-1:0]   ptch_int_q, ptch_int_d;
  logic                      s2_vld_q, s2_vld_d;
  logic signed [RATE_W-1:0]  ptch_q, ptch_d;
  logic                      ptch_vld_q, ptch_vld_d;
  logic                      sat_q, sat_d;

  // ---------------------------------------------------------------------------
  // Qualified control
  // ---------------------------------------------------------------------------
  logic cal_req;   // accepted calibration request (ignored when CAL_EN=0)
  logic take_cal;  // sample consumed by calibration
  logic take_run;  // sample entering the fusion pipeline
  logic cal_last;  // final calibration sample

  always_comb begin
    cal_req  = cal_start && (CAL_EN != 0);
    take_cal = vld && !cal_req && (state_q == ST_CAL);
    take_run = vld && !cal_req && (state_q == ST_RUN);
    cal_last = take_cal && (cnt_q == CNT_LAST);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cal_req) begin
      state_d = ST_CAL;
    end else if (cal_last) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    cal_done = (state_q == ST_RUN);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  rt_sum_new;
  logic signed [ACC_W-1:0]  az_sum_new;
  logic signed [RATE_W-1:0] rt_diff;
  logic signed [RATE_W-1:0] az_diff;
  logic signed [PRD_W-1:0]  acc_prod;
  logic signed [SUM_W-1:0]  fus;
  logic signed [SUM_W-1:0]  sum_w;

  always_comb begin
    cnt_d      = cnt_q;
    rt_sum_d   = rt_sum_q;
    az_sum_d   = az_sum_q;
    rt_off_d   = rt_off_q;
    az_off_d   = az_off_q;
    s1_vld_d   = 1'b0;
    comp_d     = comp_q;
    ptch_acc_d = ptch_acc_q;
    ptch_int_d = ptch_int_q;
    s2_vld_d   = 1'b0;
    ptch_d     = ptch_q;
    ptch_vld_d = 1'b0;
    sat_d      = sat_q;

    // Calibration accumulation; averaging is a plain arithmetic shift (floor).
    rt_sum_new = rt_sum_q + ACC_W'($signed(ptch_rt));
    az_sum_new = az_sum_q + ACC_W'($signed(AZ));

    // Stage-1 arithmetic; RATE_W subtractions wrap on purpose.
    rt_diff  = $signed(ptch_rt) - rt_off_q;
    az_diff  = $signed(AZ) - az_off_q;
    acc_prod = PRD_W'(az_diff) * PRD_W'(FUDGE_S);

    // Stage-2 arithmetic, two guard bits so clipping is detectable.
    fus   = (ptch_acc_q > ptch_q) ? FUS_P : FUS_N;
    sum_w = SUM_W'(ptch_int_q) - SUM_W'(comp_q) + fus;

    if (cal_req) begin
      cnt_d    = '0;
      rt_sum_d = '0;
      az_sum_d = '0;
      sat_d    = 1'b0;
    end else if (take_cal) begin
      cnt_d    = cnt_q + CNT_ONE;
      rt_sum_d = rt_sum_new;
      az_sum_d = az_sum_new;
      if (cal_last) begin
        rt_off_d = RATE_W'(rt_sum_new >>> CAL_LOG2);
        az_off_d = RATE_W'(az_sum_new >>> CAL_LOG2);
        rt_sum_d = '0;
        az_sum_d = '0;
      end
    end

    if (take_run) begin
      s1_vld_d   = 1'b1;
      comp_d     = INT_W'(rt_diff);
      ptch_acc_d = RATE_W'(acc_prod >>> 13);
    end

    // A calibration request freezes the integrator and drops anything in flight.
    if (s1_vld_q && !cal_req) begin
      s2_vld_d = 1'b1;
      if (sum_w > INT_MAX) begin
        ptch_int_d = INT_W'(INT_MAX);
        sat_d      = 1'b1;
      end else if (sum_w < INT_MIN) begin
        ptch_int_d = INT_W'(INT_MIN);
        sat_d      = 1'b1;
      end else begin
        ptch_int_d = INT_W'(sum_w);
      end
    end

    if (s2_vld_q && !cal_req) begin
      ptch_d     = ptch_int_q[INT_W-1:SHIFT];
      ptch_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      rt_sum_q   <= '0;
      az_sum_q   <= '0;
      rt_off_q   <= RT_OFF_DEF;
      az_off_q   <= AZ_OFF_DEF;
      s1_vld_q   <= 1'b0;
      comp_q     <= '0;
      ptch_acc_q <= '0;
      ptch_int_q <= '0;
      s2_vld_q   <= 1'b0;
      ptch_q     <= '0;
      ptch_vld_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rt_sum_q   <= rt_sum_d;
      az_sum_q   <= az_sum_d;
      rt_off_q   <= rt_off_d;
      az_off_q   <= az_off_d;
      s1_vld_q   <= s1_vld_d;
      comp_q     <= comp_d;
      ptch_acc_q <= ptch_acc_d;
      ptch_int_q <= ptch_int_d;
      s2_vld_q   <= s2_vld_d;
      ptch_q     <= ptch_d;
      ptch_vld_q <= ptch_vld_d;
      sat_q      <= sat_d;
    end
  end

  assign ptch     = ptch_q;
  assign ptch_vld = ptch_vld_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_inert_fusion_intg.sv
// Scoreboard bench for inert_fusion_intg. Three instances share one clock:
//   0: defaults (auto-calibration), 1: CAL_EN=0, 2: INT_W=20/SHIFT=4.
// Stimulus pushes the hand-derived ptch value and its due cycle into a queue;
// a monitor pops on every ptch_vld and compares.
module tb_inert_fusion_intg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0]       vld, cs, pv, cd, sat;
  logic [2:0][15:0] rt, az, ptch;

  inert_fusion_intg dut_a (
    .clk(clk), .rst(rst), .vld(vld[0]), .ptch_rt(rt[0]), .AZ(az[0]),
    .cal_start(cs[0]), .ptch(ptch[0]), .ptch_vld(pv[0]), .cal_done(cd[0]), .sat(sat[0])
  );

  inert_fusion_intg #(.CAL_EN(0)) dut_b (
    .clk(clk), .rst(rst), .vld(vld[1]), .ptch_rt(rt[1]), .AZ(az[1]),
    .cal_start(cs[1]), .ptch(ptch[1]), .ptch_vld(pv[1]), .cal_done(cd[1]), .sat(sat[1])
  );

  inert_fusion_intg #(.INT_W(20), .SHIFT(4)) dut_c (
    .clk(clk), .rst(rst), .vld(vld[2]), .ptch_rt(rt[2]), .AZ(az[2]),
    .cal_start(cs[2]), .ptch(ptch[2]), .ptch_vld(pv[2]), .cal_done(cd[2]), .sat(sat[2])
  );

  typedef struct {
    int          d;
    logic [15:0] e;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Monitor: every ptch_vld must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (pv[d] === 1'b1) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ptch_vld dut%0d: got ptch 0x%0h, expected no strobe", d, ptch[d]);
        end else begin
          mx = q.pop_front();
          chk($sformatf("dut_id(cyc %0d)", cyc), d, mx.d);
          chk($sformatf("ptch dut%0d", d), {16'h0, ptch[d]}, {16'h0, mx.e});
          chk($sformatf("latency dut%0d", d), cyc, mx.cyc);
          $display("dut%0d cycle %0d ptch 0x%04h (expected 0x%04h)", d, cyc, ptch[d], mx.e);
        end
      end
    end
  end

  // Called 1 time unit after a rising edge; drives one cycle and returns
  // 1 time unit after the edge that sampled it.
  task automatic pulse(input int d, input logic v, input logic [15:0] r, input logic [15:0] a,
                       input logic c, input logic push, input logic [15:0] e);
    exp_t x;
    vld[d] = v;
    rt[d]  = r;
    az[d]  = a;
    cs[d]  = c;
    if (push) begin
      x.d   = d;
      x.e   = e;
      x.cyc = cyc + 3;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    cs[d]  = 1'b0;
  endtask

  task automatic cal_samples(input int d, input int n, input logic [15:0] r, input logic [15:0] a);
    for (int i = 0; i < n; i++) pulse(d, 1'b1, r, a, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", q.size());
      q.delete();
    end
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    vld = '0;
    cs  = '0;
    rt  = '0;
    az  = '0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset state
    chk("reset ptch a", {16'h0, ptch[0]}, 32'h0);
    chk("reset ptch_vld a", {31'h0, pv[0]}, 32'h0);
    chk("reset cal_done a", {31'h0, cd[0]}, 32'h0);
    chk("reset sat a", {31'h0, sat[0]}, 32'h0);
    chk("reset cal_done b", {31'h0, cd[1]}, 32'h1);
    chk("reset cal_done c", {31'h0, cd[2]}, 32'h0);

    // Calibration with a restart after 8 samples (coincident sample discarded)
    cal_samples(0, 8, 16'h0058, 16'h00A0);
    pulse(0, 1'b1, 16'h7000, 16'h7000, 1'b1, 1'b0, 16'h0);
    cal_samples(0, 15, 16'h0058, 16'h00A0);
    chk("cal_done after 15", {31'h0, cd[0]}, 32'h0);
    cal_samples(0, 1, 16'h0058, 16'h00A0);
    chk("cal_done after 16", {31'h0, cd[0]}, 32'h1);

    // Spaced RUN samples: offsets 0x58/0xA0
    pulse(0, 1'b1, 16'h0058, 16'h00A0, 1'b0, 1'b1, 16'hFFFF); drain(); // int -1024
    pulse(0, 1'b1, 16'h0058, 16'h00A0, 1'b0, 1'b1, 16'h0000); drain(); // acc 0 > -1: int 0
    pulse(0, 1'b1, 16'hF058, 16'h00A0, 1'b0, 1'b1, 16'h0001); drain(); // int 3072
    pulse(0, 1'b1, 16'h0058, 16'hFCB8, 1'b0, 1'b1, 16'h0001); drain(); // acc -40: int 2048
    pulse(0, 1'b1, 16'h0058, 16'h0488, 1'b0, 1'b1, 16'h0001); drain(); // acc 39: int 3072
    pulse(0, 1'b1, 16'h8000, 16'h00A0, 1'b0, 1'b1, 16'hFFF1); drain(); // wrap: int -30632
    pulse(0, 1'b1, 16'h0058, 16'h00A0, 1'b0, 1'b1, 16'hFFF1); drain(); // int -29608
    chk("sat a after run", {31'h0, sat[0]}, 32'h0);

    // cal_start with coincident vld, then reset mid-calibration
    pulse(0, 1'b1, 16'h0058, 16'h00A0, 1'b1, 1'b0, 16'h0);
    chk("cal_done drop", {31'h0, cd[0]}, 32'h0);
    idle(4);
    cal_samples(0, 5, 16'h1000, 16'h1000);
    #2 rst = 1'b1;
    #1;
    chk("async rst ptch", {16'h0, ptch[0]}, 32'h0);
    chk("async rst cal_done", {31'h0, cd[0]}, 32'h0);
    chk("rst rt_off", {16'h0, dut_a.rt_off_q}, 32'h0050);
    chk("rst az_off", {16'h0, dut_a.az_off_q}, 32'h00A0);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Fresh calibration must take exactly 16 samples again
    cal_samples(0, 15, 16'h0058, 16'h00A0);
    chk("recal cal_done after 15", {31'h0, cd[0]}, 32'h0);
    cal_samples(0, 1, 16'h0058, 16'h00A0);
    chk("recal cal_done after 16", {31'h0, cd[0]}, 32'h1);
    pulse(0, 1'b1, 16'h0058, 16'h00A0, 1'b0, 1'b1, 16'hFFFF); drain();

    // CAL_EN=0: back-to-back samples, comp=-2048, int += 1024 each
    for (int k = 1; k <= 8; k++) begin
      pulse(1, 1'b1, 16'hF850, 16'h00A0, 1'b0, 1'b1, 16'(k / 2));
    end
    drain();
    pulse(1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0);
    chk("cal_start ignored b", {31'h0, cd[1]}, 32'h1);
    pulse(1, 1'b1, 16'hF850, 16'h00A0, 1'b0, 1'b1, 16'h0004); drain(); // int 9216

    // Saturation: INT_W=20, offsets calibrated to 0, rate -32768 repeated
    cal_samples(2, 16, 16'h0000, 16'h0000);
    chk("cal_done c", {31'h0, cd[2]}, 32'h1);
    chk("sat c before", {31'h0, sat[2]}, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      pulse(2, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, (k <= 16) ? 16'(1984 * k) : 16'h7FFF);
    end
    drain();
    chk("sat c set", {31'h0, sat[2]}, 32'h1);
    chk("ptch_int c clamp", {12'h0, dut_c.ptch_int_q}, 32'h7FFFF);
    pulse(2, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0);
    chk("sat c cleared", {31'h0, sat[2]}, 32'h0);
    chk("cal_done c drop", {31'h0, cd[2]}, 32'h0);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inert_fusion_intg.md
INERT_FUSION_INTG -- requirements
Module: inert_fusion_intg

Interface
REQ-001 SHALL provide parameter RATE_W, default 16, width of ptch_rt, AZ and ptch.
REQ-002 SHALL provide parameter INT_W, default 27, width of the pitch integrator.
REQ-003 SHALL provide parameter SHIFT, default 11, integrator-to-ptch scaling (ptch = ptch_int[INT_W-1:SHIFT]); INT_W-SHIFT SHALL equal RATE_W.
REQ-004 SHALL provide parameter FUDGE, default 327, unsigned accel-to-pitch gain; the accel product is shifted right by 13.
REQ-005 SHALL provide parameter FUS_STEP, default 1024, fusion correction magnitude.
REQ-006 SHALL provide parameter CAL_LOG2, default 4; calibration uses 2^CAL_LOG2 samples.
REQ-007 SHALL provide parameter CAL_EN, default 1; 0 disables auto-calibration.
REQ-008 SHALL provide parameters RT_OFF_DEF, default 16'h0050, and AZ_OFF_DEF, default 16'h00A0, the power-up offsets.
REQ-009 clk  input  1  sole clock, rising edge.
REQ-010 rst  input  1  asynchronous, active-high reset.
REQ-011 vld  input  1  one-cycle strobe marking a new ptch_rt/AZ sample.
REQ-012 ptch_rt  input  RATE_W signed  raw pitch rate.
REQ-013 AZ  input  RATE_W signed  raw Z acceleration.
REQ-014 cal_start  input  1  one-cycle request to (re)calibrate offsets.
REQ-015 ptch  output  RATE_W signed  fused pitch.
REQ-016 ptch_vld  output  1  one-cycle strobe marking ptch updated from a new sample.
REQ-017 cal_done  output  1  level, high while offsets are valid (RUN state).
REQ-018 sat  output  1  sticky flag, integrator saturated.

Function
REQ-019 SHALL implement two states, CAL and RUN; after reset the state SHALL be CAL if CAL_EN=1, else RUN.
REQ-020 In CAL, each vld SHALL add sign-extended ptch_rt and AZ into (RATE_W+CAL_LOG2)-bit accumulators and increment a sample counter.
REQ-021 On the 2^CAL_LOG2-th vld in CAL, rt_off and az_off SHALL load sum>>>CAL_LOG2 (arithmetic, floor); the state SHALL enter RUN on the next cycle and cal_done SHALL rise in that cycle.
REQ-022 In CAL, ptch_int and ptch SHALL hold and ptch_vld SHALL stay low.
REQ-023 cal_start in RUN with CAL_EN=1 SHALL enter CAL next cycle: clear accumulators and counter, drop cal_done, clear sat, kill in-flight pipeline stage, and hold ptch_int; any vld in the same cycle SHALL be discarded.
REQ-024 cal_start in CAL SHALL restart the count from zero and discard a coincident vld; cal_start with CAL_EN=0 SHALL be ignored.
REQ-025 Stage 1 (RUN, on vld) SHALL register comp = ptch_rt - rt_off, sign-extended to INT_W, and ptch_acc = ((AZ - az_off) * FUDGE) >>> 13, truncated to RATE_W, plus s1_vld.
REQ-026 Stage 2 (on s1_vld) SHALL compute ptch_int - comp + f, with f = +FUS_STEP if ptch_acc > ptch (signed) else -FUS_STEP, in INT_W+2 bits.
REQ-027 The stage-2 result SHALL saturate to the signed INT_W range before being stored, and sat SHALL set on any clipping.
REQ-028 ptch SHALL be registered from the updated ptch_int one cycle after stage 2.
REQ-029 Latency SHALL be: vld at cycle N gives ptch and ptch_vld at N+3; back-to-back vld SHALL be accepted every cycle.
REQ-030 RATE_W-bit subtractions SHALL wrap (no saturation); only the integrator saturates.

Reset
REQ-031 rst SHALL asynchronously clear ptch_int, ptch, ptch_vld, sat, the pipeline, the accumulators and the counter.
REQ-032 rst SHALL set rt_off=RT_OFF_DEF and az_off=AZ_OFF_DEF, and set the state per REQ-019; cal_done SHALL be 0 if CAL_EN=1, else 1.
REQ-033 rst asserted mid-calibration or mid-pipeline SHALL discard all partial work.

Verification
REQ-034 Defaults, 16 vld samples with ptch_rt=0x0058 and AZ=0x00A0 -> rt_off=0x0058, az_off=0x00A0, cal_done high the cycle after the 16th vld.
REQ-035 RUN after REQ-034, one vld with ptch_rt=0x0058 and AZ=0x00A0 -> ptch_acc=0 and ptch_int=-1024; 3 cycles later ptch=0xFFFF and ptch_vld pulses once.
REQ-036 RUN with rt_off=0x0050, vld every cycle with ptch_rt=0x0050-2048 and AZ=0x00A0 -> the first update is ptch_int=2048-1024=1024 (ptch still 0), and ptch rises monotonically with no gaps in ptch_vld.
REQ-037 INT_W=20, SHIFT=4, ptch_rt=-32768 repeated -> ptch_int clamps at 0x7FFFF, ptch=0x7FFF, sat=1; cal_start then clears sat.
REQ-038 cal_start coincident with vld in RUN, then rst after the 5th calibration vld -> no ptch_vld for the discarded sample, cal_done low, offsets at defaults after reset.
